// File: rtl/pau_scheduler.sv
// pau_scheduler: round-robin arbiter that shares one posit arithmetic unit
// among NUM_REQ requesters. It latches one op, drives the PAU through a
// settle/timeout window, and then returns the result to the issuer.
module pau_scheduler #(
    parameter int NUM_REQ        = 2,
    parameter int N              = 16,
    parameter int WAIT_CYCLES    = 3,
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [3*NUM_REQ-1:0] req_op,
    input  logic [N*NUM_REQ-1:0] req_a,
    input  logic [N*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]   rsp_valid,
    input  logic [NUM_REQ-1:0]   rsp_ready,
    output logic [N-1:0]         rsp_data,
    output logic                 rsp_err,
    output logic                 pau_start,
    output logic [1:0]           pau_sel,
    output logic [N-1:0]         pau_a,
    output logic [N-1:0]         pau_b,
    input  logic                 pau_done,
    input  logic [N-1:0]         pau_result,
    output logic                 busy
);

    localparam int          TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NR    = NUM_REQ;
    localparam logic [N-1:0] NAR  = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_e;

    state_e             state_q;
    logic [TAG_W-1:0]   rr_ptr_q;
    logic [TAG_W-1:0]   tag_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [N-1:0]       rsp_data_q;
    logic               rsp_err_q;
    logic [1:0]         pau_sel_q;
    logic [N-1:0]       pau_a_q;
    logic [N-1:0]       pau_b_q;
    logic               live_q;
    logic [1:0]         rst_sync_q;
    logic               rst_int_n;

    logic               win_any;
    logic [TAG_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_oh;
    logic [2:0]         win_op;
    logic [N-1:0]       win_a;
    logic [N-1:0]       win_b;
    logic [NUM_REQ-1:0] tag_oh;

    // Reset synchronizer: asserts asynchronously, releases on clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_int_n = rst_sync_q[1];

    // Round-robin winner search starting at rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        int unsigned idx;
        idx     = 0;
        win_any = 1'b0;
        win_idx = '0;
        win_oh  = '0;
        win_op  = '0;
        win_a   = '0;
        win_b   = '0;
        for (int unsigned j = 0; j < NR; j++) begin
            idx = 32'(rr_ptr_q) + j;
            if (idx >= NR) idx = idx - NR;
            for (int unsigned i = 0; i < NR; i++) begin
                if (!win_any && idx == i && req_valid[i]) begin
                    win_any   = 1'b1;
                    win_idx   = TAG_W'(i);
                    win_oh[i] = 1'b1;
                    win_op    = req_op[3*i +: 3];
                    win_a     = req_a[N*i +: N];
                    win_b     = req_b[N*i +: N];
                end
            end
        end
    end

    // One-hot decode of the tag that owns the pending response
    always_comb begin
        tag_oh = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (tag_q == TAG_W'(i)) tag_oh[i] = 1'b1;
        end
    end

    // Scheduler FSM: accept, execute on the PAU, respond
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            tag_q      <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            pau_sel_q  <= 2'b00;
            pau_a_q    <= '0;
            pau_b_q    <= '0;
            live_q     <= 1'b0;
        end else begin
            live_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (win_any && live_q) begin
                        tag_q <= win_idx;
                        if (win_op[2]) begin
                            rsp_data_q <= NAR;
                            rsp_err_q  <= 1'b1;
                            state_q    <= ST_RESP;
                        end else begin
                            cnt_q   <= '0;
                            pau_a_q <= win_a;
                            pau_b_q <= (win_op[1:0] == 2'b01) ? (~win_b) + N'(1) : win_b;
                            case (win_op[1:0])
                                2'b00, 2'b01: pau_sel_q <= 2'b00;
                                2'b10:        pau_sel_q <= 2'b01;
                                default:      pau_sel_q <= 2'b10;
                            endcase
                            state_q <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q >= CNT_W'(WAIT_CYCLES) && pau_done) begin
                        rsp_data_q <= pau_result;
                        rsp_err_q  <= 1'b0;
                        state_q    <= ST_RESP;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                        rsp_data_q <= NAR;
                        rsp_err_q  <= 1'b1;
                        state_q    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (|(rsp_ready & tag_oh)) begin
                        rr_ptr_q <= (tag_q == TAG_W'(NUM_REQ-1)) ? '0 : tag_q + TAG_W'(1);
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE && live_q) ? win_oh : '0;
    assign rsp_valid = (state_q == ST_RESP) ? tag_oh : '0;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign pau_start = (state_q == ST_EXEC);
    assign pau_sel   = pau_sel_q;
    assign pau_a     = pau_a_q;
    assign pau_b     = pau_b_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pau_scheduler.sv
// Directed plus randomized bench for pau_scheduler; the expected winner,
// latency and result of each transaction come from a transaction-level model.
module tb_pau_scheduler;

    localparam int NR   = 2;
    localparam int N    = 16;
    localparam int WAIT = 3;
    localparam int TMO  = 15;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [3*NR-1:0] req_op;
    logic [N*NR-1:0] req_a;
    logic [N*NR-1:0] req_b;
    logic [NR-1:0]   rsp_valid;
    logic [NR-1:0]   rsp_ready;
    logic [N-1:0]    rsp_data;
    logic            rsp_err;
    logic            pau_start;
    logic [1:0]      pau_sel;
    logic [N-1:0]    pau_a;
    logic [N-1:0]    pau_b;
    logic            pau_done;
    logic [N-1:0]    pau_result;
    logic            busy;

    pau_scheduler #(
        .NUM_REQ(NR), .N(N), .WAIT_CYCLES(WAIT), .TIMEOUT_CYCLES(TMO), .CNT_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .pau_start(pau_start), .pau_sel(pau_sel),
        .pau_a(pau_a), .pau_b(pau_b), .pau_done(pau_done),
        .pau_result(pau_result), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int model_ptr   = 0;

    logic [2:0]   op_t [NR];
    logic [N-1:0] a_t  [NR];
    logic [N-1:0] b_t  [NR];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "/req_ready"}, 32'(req_ready), 0);
        chk({nm, "/rsp_valid"}, 32'(rsp_valid), 0);
        chk({nm, "/rsp_data"},  32'(rsp_data),  0);
        chk({nm, "/rsp_err"},   32'(rsp_err),   0);
        chk({nm, "/pau_start"}, 32'(pau_start), 0);
        chk({nm, "/pau_sel"},   32'(pau_sel),   0);
        chk({nm, "/pau_a"},     32'(pau_a),     0);
        chk({nm, "/pau_b"},     32'(pau_b),     0);
        chk({nm, "/busy"},      32'(busy),      0);
    endtask

    task automatic drive_reqs(input logic [NR-1:0] mask);
        req_valid = mask;
        for (int i = 0; i < NR; i++) begin
            req_op[3*i +: 3] = op_t[i];
            req_a[N*i +: N]  = a_t[i];
            req_b[N*i +: N]  = b_t[i];
        end
    endtask

    function automatic int model_winner(input logic [NR-1:0] mask);
        for (int j = 0; j < NR; j++) begin
            if (mask[(model_ptr + j) % NR]) return (model_ptr + j) % NR;
        end
        return 0;
    endfunction

    // One full transaction: d is the EXEC cycle at which the PAU model raises
    // done (held afterwards); bp is the number of backpressure cycles.
    task automatic txn(input logic [NR-1:0] mask, input int d, input logic [N-1:0] res,
                       input int bp, input string nm);
        int w, n, exp_lat, eff;
        logic [2:0] op;
        logic legal, exp_err;
        logic [N-1:0] exp_data, exp_b;
        logic [1:0] exp_sel;
        drive_reqs(mask);
        rsp_ready  = '0;
        pau_done   = 1'b0;
        pau_result = res;
        #1;
        w = model_winner(mask);
        chk({nm, "/req_ready"}, 32'(req_ready), 32'(1) << w);
        op    = op_t[w];
        legal = (op < 3'd4);
        exp_b = (op == 3'd1) ? N'(((1 << N) - int'(b_t[w])) % (1 << N)) : b_t[w];
        exp_sel = (op == 3'd2) ? 2'd1 : (op == 3'd3) ? 2'd2 : 2'd0;
        eff = (d > WAIT) ? d : WAIT;
        if (!legal) begin
            exp_lat = 1; exp_err = 1'b1; exp_data = 16'h8000;
        end else if (eff <= TMO) begin
            exp_lat = eff + 2; exp_err = 1'b0; exp_data = res;
        end else begin
            exp_lat = TMO + 2; exp_err = 1'b1; exp_data = 16'h8000;
        end
        @(posedge clk);
        n = 1;
        forever begin
            @(negedge clk);
            if (rsp_valid !== '0) break;
            if (n > TMO + 4) break;
            chk({nm, "/pau_start"}, 32'(pau_start), 1);
            if (n == 1) begin
                chk({nm, "/pau_a"},   32'(pau_a),   32'(a_t[w]));
                chk({nm, "/pau_b"},   32'(pau_b),   32'(exp_b));
                chk({nm, "/pau_sel"}, 32'(pau_sel), 32'(exp_sel));
                chk({nm, "/busy"},    32'(busy),    1);
            end
            pau_done = ((n - 1) >= d);
            @(posedge clk);
            n++;
        end
        pau_done = 1'b0;
        chk({nm, "/latency"},   32'(n),         32'(exp_lat));
        chk({nm, "/rsp_valid"}, 32'(rsp_valid), 32'(1) << w);
        chk({nm, "/rsp_data"},  32'(rsp_data),  32'(exp_data));
        chk({nm, "/rsp_err"},   32'(rsp_err),   32'(exp_err));
        chk({nm, "/rsp_start"}, 32'(pau_start), 0);
        for (int k = 0; k < bp; k++) begin
            rsp_ready = NR'($urandom) & ~(NR'(1) << w);
            @(posedge clk);
            @(negedge clk);
            chk({nm, "/bp_valid"}, 32'(rsp_valid), 32'(1) << w);
            chk({nm, "/bp_data"},  32'(rsp_data),  32'(exp_data));
            chk({nm, "/bp_ready"}, 32'(req_ready), 0);
        end
        rsp_ready = NR'($urandom) | (NR'(1) << w);
        @(posedge clk);
        @(negedge clk);
        rsp_ready = '0;
        req_valid = '0;
        #1;
        chk({nm, "/idle_busy"},  32'(busy),      0);
        chk({nm, "/idle_valid"}, 32'(rsp_valid), 0);
        model_ptr = (w + 1) % NR;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] mask;
        rst_n      = 1'b0;
        pau_done   = 1'b0;
        pau_result = '0;
        rsp_ready  = '0;
        for (int i = 0; i < NR; i++) begin
            op_t[i] = 3'd0; a_t[i] = N'($urandom); b_t[i] = N'($urandom);
        end
        drive_reqs('1);
        repeat (3) @(negedge clk);
        #1;
        chk_reset("por");
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '0;
        repeat (4) @(negedge clk);

        // Single add with early done
        op_t[0] = 3'd0; a_t[0] = 16'h4000; b_t[0] = 16'h4000;
        txn(2'b01, 0, 16'h5000, 0, "add");

        // Subtraction negates operand B
        op_t[1] = 3'd1; a_t[1] = 16'h1234; b_t[1] = 16'h4000;
        txn(2'b10, 4, 16'h0C00, 1, "sub_4000");
        b_t[1] = 16'h0000;
        txn(2'b10, 3, 16'h1234, 0, "sub_0000");
        b_t[1] = 16'h8000;
        txn(2'b10, 5, 16'h8000, 0, "sub_8000");

        // Round-robin with both requesting
        op_t[0] = 3'd2; op_t[1] = 3'd3;
        for (int k = 0; k < 4; k++) begin
            a_t[0] = N'($urandom); b_t[0] = N'($urandom);
            a_t[1] = N'($urandom); b_t[1] = N'($urandom);
            txn(2'b11, k, N'($urandom), 0, "rr");
        end

        // Timeout, done-at-timeout tie, illegal op
        op_t[0] = 3'd0;
        txn(2'b01, 99, 16'h1111, 0, "timeout");
        op_t[1] = 3'd2;
        txn(2'b10, 15, 16'h2222, 0, "tie");
        op_t[0] = 3'd1;
        txn(2'b01, 16, 16'h3333, 0, "late");
        op_t[1] = 3'd4;
        txn(2'b10, 0, 16'h4444, 0, "illegal");

        // Long backpressure
        op_t[0] = 3'd2;
        txn(2'b11, 6, 16'h5A5A, 10, "backpressure");

        // Randomized transactions
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < NR; i++) begin
                op_t[i] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7))
                                                      : 3'($urandom_range(0, 3));
                a_t[i] = N'($urandom);
                b_t[i] = N'($urandom);
            end
            mask = NR'($urandom_range(1, (1 << NR) - 1));
            txn(mask, $urandom_range(0, 17), N'($urandom), $urandom_range(0, 3), "rand");
        end

        // Reset during EXEC drops the op and the round-robin pointer
        op_t[0] = 3'd0; op_t[1] = 3'd0;
        txn(2'b01, 3, 16'h0101, 0, "pre_rst");
        drive_reqs(2'b01);
        @(posedge clk);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_reset("mid_rst");
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '0;
        repeat (4) @(negedge clk);
        chk("post_rst/rsp_valid", 32'(rsp_valid), 0);
        chk("post_rst/busy",      32'(busy),      0);
        model_ptr = 0;
        txn(2'b11, 3, 16'h0202, 0, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pau_scheduler.md
Name: pau_scheduler

Overview:
- Round-robin scheduler that shares one external posit arithmetic unit (PAU: posit_add/posit_mult/posit_div, N=16, es=1) among NUM_REQ requesters.
- Arbitrates requests, drives operands and op select into the PAU, and enforces the minimum settle time and a timeout.
- Returns each result to the requester that issued it over a valid/ready response channel.
- Sits between the custom-instruction front ends (CV-X-IF adapters, DMA-style posit engines) and the single PAU instance.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- N, 16, posit width.
- WAIT_CYCLES, 3, minimum EXEC cycles before pau_done is honoured.
- TIMEOUT_CYCLES, 15, EXEC cycle count at which the op aborts with error; must be > WAIT_CYCLES.
- CNT_W, 4, counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester request accept
- req_op  in  3*NUM_REQ  op per requester (slice i = [3i+2:3i]): 000 add, 001 sub, 010 mul, 011 div, 1xx illegal
- req_a  in  N*NUM_REQ  operand A per requester
- req_b  in  N*NUM_REQ  operand B per requester
- rsp_valid  out  NUM_REQ  one-hot response valid
- rsp_ready  in  NUM_REQ  per-requester response accept
- rsp_data  out  N  result, shared by all requesters
- rsp_err  out  1  result is an error (NaR returned)
- pau_start  out  1  PAU start, held high through EXEC
- pau_sel  out  2  00 add, 01 mul, 10 div
- pau_a  out  N  PAU operand A
- pau_b  out  N  PAU operand B
- pau_done  in  1  PAU done, OR of the unit done flags
- pau_result  in  N  result of the selected unit (external mux on pau_sel)
- busy  out  1  scheduler not in IDLE

Behaviour:
- Reset (async assert, sync deassert internally):
  - state=IDLE, rr_ptr=0, counter=0, tag=0.
  - All outputs 0, including rsp_data, pau_a, pau_b and pau_sel.
  - An in-flight op is dropped; no response is produced for it.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Winner = first i with req_valid[i], scanning from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready is one-hot on the winner and combinational from req_valid; it is 0 in all other states.
  - On handshake: latch op, a, b and tag=winner.
  - Legal op -> EXEC with counter=0.
  - Illegal op -> RESP directly, with rsp_data = NaR (1 followed by N-1 zeros) and rsp_err=1.
- Operand mapping, registered at acceptance:
  - pau_a = a.
  - pau_b = b, except for sub: pau_b = (~b + 1) mod 2^N, the posit negation. NaR and 0 map to themselves.
  - pau_sel = 00 for add/sub, 01 for mul, 10 for div.
  - pau_a, pau_b and pau_sel hold their values until the next acceptance.
- EXEC:
  - pau_start=1 and counter increments each cycle.
  - Transition on the cycle where counter >= WAIT_CYCLES and pau_done=1: capture pau_result into rsp_data, rsp_err=0, go to RESP. pau_done before WAIT_CYCLES is ignored.
  - If counter == TIMEOUT_CYCLES without the done condition: rsp_data = NaR, rsp_err=1, go to RESP.
  - Done and timeout in the same cycle: done wins.
- RESP:
  - rsp_valid[tag]=1; rsp_data and rsp_err are stable.
  - rsp_ready of non-tag requesters is ignored.
  - On rsp_ready[tag]: go to IDLE and set rr_ptr = (tag+1) mod NUM_REQ.
  - No new request is accepted in the cycle the response completes.
- Latency: accept (cycle 0) -> EXEC from cycle 1 -> earliest rsp_valid at cycle WAIT_CYCLES+2. At most one op in flight.
- Fairness: a continuously requesting requester is served within NUM_REQ grants.
- busy = (state != IDLE).

Test Plan:
- Single add: req0 op=000, a=0x4000, b=0x4000; model asserts pau_done at EXEC cycle 0 with result 0x5000 -> done ignored until counter=3; rsp_valid=01 at cycle 5, rsp_data=0x5000, rsp_err=0.
- Sub negation: req1 op=001, b=0x4000 -> pau_b=0xC000, pau_sel=00. Sub with b=0x0000 -> pau_b=0x0000. Sub with b=0x8000 -> pau_b=0x8000.
- Round-robin: both requesters hold req_valid with ops mul and div -> grant order 0,1,0,1; pau_sel 01 then 10; each rsp_valid asserted only on the granted index.
- Timeout: pau_done held 0 -> at counter=15, rsp_data=0x8000 and rsp_err=1. Illegal op 100 -> rsp_err=1 with no pau_start pulse.
- Backpressure: rsp_ready held low 10 cycles -> rsp_valid and rsp_data stable, req_ready=0 throughout.
- Reset mid-op: drop rst_n during EXEC -> all outputs 0 asynchronously; after release no stale rsp_valid, rr_ptr=0.
